// File: rtl/mu_pkg.sv
// ---------------------------------------------------------------------------
// mu_pkg
// Shared definitions for the frame-RAM read-side streaming blocks.
//   state_t    : read sequencer FSM states
//   FRAME_W/H  : default thermal frame geometry (32 x 24)
//   FRAME_LEN  : default words per frame
// ---------------------------------------------------------------------------
package mu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int FRAME_W   = 32;
    localparam int FRAME_H   = 24;
    localparam int FRAME_LEN = FRAME_W * FRAME_H;

endpackage

// File: rtl/mu_skid_fifo2.sv
// ---------------------------------------------------------------------------
// mu_skid_fifo2
// Two-entry FIFO used as a skid buffer behind a registered-read RAM.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write wdata this cycle (caller guarantees not full)
//   pop        : remove head this cycle (ignored when empty)
//   wdata      : data to write
//   rdata      : current head entry
//   empty/full : occupancy flags
//   count      : number of stored entries (0..2)
// ---------------------------------------------------------------------------
module mu_skid_fifo2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          empty,
    output logic          full,
    output logic [1:0]    count
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic          do_pop;

    assign do_pop = pop & ~empty;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: only two entries, so the storage is reset too; this keeps
            // the head (and therefore the stream data output) at zero after reset.
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == 2'd0);
    assign full  = (count == 2'd2);

endmodule

// File: rtl/mu_ram_rd_stream.sv
// ---------------------------------------------------------------------------
// mu_ram_rd_stream
// Read-side sequencer for the simple dual-port frame RAM. On start it walks
// FRAME_LEN consecutive addresses from a latched base (wrapping modulo 2^AW),
// absorbs the RAM's one-cycle read latency through a 2-entry skid FIFO and
// presents the pixels as a valid/ready stream at one beat per cycle.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, base_addr  : frame request and first read address
//   busy, done        : frame in progress / one-cycle completion pulse
//   ram_raddr, ram_re : RAM read address and enable
//   ram_rd            : RAM read data, valid the cycle after ram_re
//   m_valid, m_ready  : output stream handshake
//   m_data, m_last    : pixel and end-of-frame marker
// Optional (macro MU_RAM_RD_STREAM_XY_EN):
//   LINE_W parameter; m_x, m_y head-beat column/row; m_eol end-of-line flag.
// ---------------------------------------------------------------------------
module mu_ram_rd_stream
    import mu_pkg::*;
#(
    parameter int DW        = 8,
    parameter int AW        = 10,
    parameter int FRAME_LEN = mu_pkg::FRAME_LEN
`ifdef MU_RAM_RD_STREAM_XY_EN
    ,
    parameter int LINE_W    = mu_pkg::FRAME_W
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ram_raddr,
    output logic          ram_re,
    input  logic [DW-1:0] ram_rd,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last
`ifdef MU_RAM_RD_STREAM_XY_EN
    ,
    output logic [(LINE_W > 1 ? $clog2(LINE_W) : 1)-1:0] m_x,
    output logic [((FRAME_LEN / LINE_W) > 1 ? $clog2(FRAME_LEN / LINE_W) : 1)-1:0] m_y,
    output logic          m_eol
`endif
);

    // Counters must be able to hold FRAME_LEN itself (issue count at the end).
    localparam int             CW     = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0]  LEN_C  = CW'(FRAME_LEN);
    localparam logic [CW-1:0]  LAST_C = CW'(FRAME_LEN - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [CW-1:0] issued_q;
    logic [CW-1:0] beat_q;       // index of the beat currently at the FIFO head
    logic          inflight_q;   // a read was issued last cycle; data arrives now
    logic          done_q;
    logic          start_acc;
    logic          last_pop;
    logic          pop;
    logic          credit_ok;
    logic          fifo_empty;
    logic          fifo_full;
    logic [1:0]    fifo_count;

    assign pop = m_valid & m_ready;

    // Issue only if the FIFO can still take the returning word: entries held
    // plus the word in flight, minus the one leaving this cycle, must be < 2.
    assign credit_ok = ({1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d   = state_q;
        ram_re    = 1'b0;
        start_acc = 1'b0;
        last_pop  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (issued_q == LEN_C) begin
                    state_d = ST_DRAIN;
                end else begin
                    ram_re = credit_ok;
                end
            end
            ST_DRAIN: begin
                if (pop && m_last) begin
                    last_pop = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            issued_q   <= '0;
            beat_q     <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= ram_re;
            done_q     <= last_pop;
            if (start_acc) begin
                addr_q   <= base_addr;
                issued_q <= '0;
                beat_q   <= '0;
            end else begin
                if (ram_re) begin
                    addr_q   <= addr_q + AW'(1);
                    issued_q <= issued_q + CW'(1);
                end
                if (pop) begin
                    beat_q <= beat_q + CW'(1);
                end
            end
        end
    end

    mu_skid_fifo2 #(
        .DW (DW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .pop   (pop),
        .wdata (ram_rd),
        .rdata (m_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // The credit rule must make a push into a full FIFO impossible.
    assert property (@(posedge clk) disable iff (!rst_n) !(inflight_q && fifo_full));

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign ram_raddr = addr_q;
    assign m_valid   = ~fifo_empty;
    assign m_last    = m_valid && (beat_q == LAST_C);

`ifdef MU_RAM_RD_STREAM_XY_EN
    localparam int XW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int YW = ((FRAME_LEN / LINE_W) > 1) ? $clog2(FRAME_LEN / LINE_W) : 1;

    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else if (start_acc) begin
            x_q <= '0;
            y_q <= '0;
        end else if (pop) begin
            if (x_q == XW'(LINE_W - 1)) begin
                x_q <= '0;
                y_q <= y_q + YW'(1);
            end else begin
                x_q <= x_q + XW'(1);
            end
        end
    end

    assign m_x   = x_q;
    assign m_y   = y_q;
    assign m_eol = (x_q == XW'(LINE_W - 1));
`endif

endmodule

// File: tb/tb_mu_ram_rd_stream.sv
// ---------------------------------------------------------------------------
// tb_mu_ram_rd_stream
// Self-checking bench: two sequencer instances (full 768-word frame, and an
// 8-word frame starting near the top of the address space), each paired with
// a registered-read frame RAM model preloaded with mem[i] = i[7:0]. Expected
// beats are queued when a frame is started and compared as they are accepted.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mu_ram_rd_stream;

    localparam int DW   = 8;
    localparam int AW   = 10;
    localparam int FL_A = mu_pkg::FRAME_LEN;
    localparam int FL_B = 8;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            idx;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [DW-1:0] mem [1 << AW];

    // Instance A signals
    logic          start_a, busy_a, done_a, re_a, valid_a, ready_a, last_a;
    logic [AW-1:0] base_a, raddr_a;
    logic [DW-1:0] rd_a, data_a;
    // Instance B signals
    logic          start_b, busy_b, done_b, re_b, valid_b, ready_b, last_b;
    logic [AW-1:0] base_b, raddr_b;
    logic [DW-1:0] rd_b, data_b;
`ifdef MU_RAM_RD_STREAM_XY_EN
    logic [4:0] x_a, y_a;
    logic       eol_a;
    logic [1:0] x_b;
    logic [0:0] y_b;
    logic       eol_b;
`endif

    mu_ram_rd_stream #(
        .DW (DW), .AW (AW), .FRAME_LEN (FL_A)
    ) dut_a (
        .clk (clk), .rst_n (rst_n), .start (start_a), .base_addr (base_a),
        .busy (busy_a), .done (done_a), .ram_raddr (raddr_a), .ram_re (re_a),
        .ram_rd (rd_a), .m_valid (valid_a), .m_ready (ready_a),
        .m_data (data_a), .m_last (last_a)
`ifdef MU_RAM_RD_STREAM_XY_EN
        , .m_x (x_a), .m_y (y_a), .m_eol (eol_a)
`endif
    );

    mu_ram_rd_stream #(
        .DW (DW), .AW (AW), .FRAME_LEN (FL_B)
`ifdef MU_RAM_RD_STREAM_XY_EN
        , .LINE_W (4)
`endif
    ) dut_b (
        .clk (clk), .rst_n (rst_n), .start (start_b), .base_addr (base_b),
        .busy (busy_b), .done (done_b), .ram_raddr (raddr_b), .ram_re (re_b),
        .ram_rd (rd_b), .m_valid (valid_b), .m_ready (ready_b),
        .m_data (data_b), .m_last (last_b)
`ifdef MU_RAM_RD_STREAM_XY_EN
        , .m_x (x_b), .m_y (y_b), .m_eol (eol_b)
`endif
    );

    // Registered-read RAM models
    always @(posedge clk) if (re_a) rd_a <= mem[raddr_a];
    always @(posedge clk) if (re_b) rd_b <= mem[raddr_b];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    beat_t         qa[$];
    beat_t         qb[$];
    logic [AW-1:0] addr_log[$];
    beat_t         ea, eb;

    int   issue_a, pops_a, done_cnt, first_valid_cyc, last_pop_cyc, done_cyc;
    logic prev_stall;
    logic [DW-1:0] prev_data;
    logic prev_last;
    logic rand_ready = 1'b0;

    // Monitor A: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (re_a) issue_a++;
            if (done_a) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (valid_a && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall) begin
                check("a_stall_valid", 32'(valid_a), 32'd1);
                check("a_stall_data", 32'(data_a), 32'(prev_data));
                check("a_stall_last", 32'(last_a), 32'(prev_last));
            end
            if (valid_a && ready_a) begin
                check("a_beat_expected", 32'(qa.size() > 0), 32'd1);
                if (qa.size() > 0) begin
                    ea = qa.pop_front();
                    check("a_data", 32'(data_a), 32'(ea.data));
                    check("a_last", 32'(last_a), 32'(ea.last));
`ifdef MU_RAM_RD_STREAM_XY_EN
                    check("a_x", 32'(x_a), ea.idx % 32);
                    check("a_y", 32'(y_a), ea.idx / 32);
                    check("a_eol", 32'(eol_a), 32'((ea.idx % 32) == 31));
`endif
                end
                pops_a++;
                if (last_a) last_pop_cyc = cyc;
            end
            prev_stall = valid_a && !ready_a;
            prev_data  = data_a;
            prev_last  = last_a;
        end
    end

    // Monitor B
    always @(negedge clk) begin
        if (rst_n) begin
            if (re_b) addr_log.push_back(raddr_b);
            if (valid_b && ready_b) begin
                check("b_beat_expected", 32'(qb.size() > 0), 32'd1);
                if (qb.size() > 0) begin
                    eb = qb.pop_front();
                    check("b_data", 32'(data_b), 32'(eb.data));
                    check("b_last", 32'(last_b), 32'(eb.last));
                end
            end
        end
    end

    // Random backpressure driver for instance A
    always @(posedge clk) begin
        #1;
        if (rand_ready) ready_a = 1'($urandom_range(0, 1));
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_stats();
        issue_a         = 0;
        pops_a          = 0;
        done_cnt        = 0;
        first_valid_cyc = -1;
        last_pop_cyc    = -1;
        done_cyc        = -1;
    endtask

    // Queue the expected frame, then pulse start; returns with cyc = accept edge.
    task automatic start_frame_a(input logic [AW-1:0] base);
        logic [AW-1:0] a;
        for (int i = 0; i < FL_A; i++) begin
            a = base + AW'(i);
            qa.push_back('{data: a[DW-1:0], last: (i == FL_A - 1), idx: i});
        end
        base_a  = base;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic wait_idle_a(input int budget, input string tag);
        int n = 0;
        while ((qa.size() != 0 || busy_a) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, 32'(qa.size()), 32'd0);
        check({tag, "_idle"}, 32'(busy_a), 32'd0);
        tick(2);
    endtask

    int s_cyc;
    int n;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i);
        rst_n   = 1'b0;
        start_a = 1'b0; base_a = '0; ready_a = 1'b1;
        start_b = 1'b0; base_b = '0; ready_b = 1'b1;
        reset_stats();
        tick(3);

        // Reset values
        check("rst_busy",  32'(busy_a),  32'd0);
        check("rst_done",  32'(done_a),  32'd0);
        check("rst_re",    32'(re_a),    32'd0);
        check("rst_raddr", 32'(raddr_a), 32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_data",  32'(data_a),  32'd0);
        check("rst_last",  32'(last_a),  32'd0);
        rst_n = 1'b1;
        tick(2);

        // T1: full frame, ready held high
        reset_stats();
        start_frame_a('0);
        s_cyc = cyc;
        check("t1_busy", 32'(busy_a), 32'd1);
        wait_idle_a(2000, "t1");
        check("t1_first_valid_lat", 32'(first_valid_cyc - s_cyc), 32'd2);
        check("t1_last_beat_lat", 32'(last_pop_cyc - s_cyc), 32'(FL_A + 1));
        check("t1_span", 32'(last_pop_cyc - first_valid_cyc), 32'(FL_A - 1));
        check("t1_done_lat", 32'(done_cyc - last_pop_cyc), 32'd1);
        check("t1_done_cnt", 32'(done_cnt), 32'd1);
        check("t1_issues", 32'(issue_a), 32'(FL_A));
        check("t1_pops", 32'(pops_a), 32'(FL_A));

        // T2: random backpressure, plus a start pulse while busy (ignored)
        reset_stats();
        rand_ready = 1'b1;
        start_frame_a('0);
        tick(50);
        base_a  = 10'd512;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_idle_a(5000, "t2");
        rand_ready = 1'b0;
        ready_a    = 1'b1;
        check("t2_issues", 32'(issue_a), 32'(FL_A));
        check("t2_pops", 32'(pops_a), 32'(FL_A));
        check("t2_done_cnt", 32'(done_cnt), 32'd1);

        // T3: start accepted in the done cycle
        reset_stats();
        start_frame_a('0);
        n = 0;
        while (!done_a && n < 2000) begin
            tick();
            n++;
        end
        check("t3_done_seen", 32'(done_a), 32'd1);
        start_frame_a('0);
        check("t3_busy_again", 32'(busy_a), 32'd1);
        wait_idle_a(2000, "t3");
        check("t3_done_cnt", 32'(done_cnt), 32'd2);
        check("t3_issues", 32'(issue_a), 32'(2 * FL_A));
        check("t3_pops", 32'(pops_a), 32'(2 * FL_A));

        // T4: ready low for 10 cycles after start -> exactly two reads issued
        reset_stats();
        ready_a = 1'b0;
        start_frame_a('0);
        tick(9);
        check("t4_stall_issues", 32'(issue_a), 32'd2);
        check("t4_stall_valid", 32'(valid_a), 32'd1);
        check("t4_stall_head", 32'(data_a), 32'd0);
        ready_a = 1'b1;
        wait_idle_a(2000, "t4");
        check("t4_pops", 32'(pops_a), 32'(FL_A));
        check("t4_issues", 32'(issue_a), 32'(FL_A));

        // T5: reset mid-frame, then a clean frame
        reset_stats();
        start_frame_a('0);
        n = 0;
        while (pops_a < 100 && n < 2000) begin
            tick();
            n++;
        end
        check("t5_reached_100", 32'(pops_a >= 100), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_busy",  32'(busy_a),  32'd0);
        check("t5_rst_re",    32'(re_a),    32'd0);
        check("t5_rst_raddr", 32'(raddr_a), 32'd0);
        check("t5_rst_valid", 32'(valid_a), 32'd0);
        check("t5_rst_data",  32'(data_a),  32'd0);
        check("t5_rst_last",  32'(last_a),  32'd0);
        check("t5_rst_done",  32'(done_a),  32'd0);
        qa.delete();
        tick(2);
        rst_n = 1'b1;
        tick(2);
        reset_stats();
        start_frame_a('0);
        wait_idle_a(2000, "t5");
        check("t5_pops", 32'(pops_a), 32'(FL_A));

        // T6: 8-word frame wrapping past the top of the address space
        addr_log.delete();
        for (int i = 0; i < FL_B; i++) begin
            logic [AW-1:0] a;
            a = 10'd1020 + AW'(i);
            qb.push_back('{data: a[DW-1:0], last: (i == FL_B - 1), idx: i});
        end
        base_b  = 10'd1020;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        while ((qb.size() != 0 || busy_b) && n < 100) begin
            tick();
            n++;
        end
        tick(2);
        check("t6_drained", 32'(qb.size()), 32'd0);
        check("t6_issue_cnt", 32'(addr_log.size()), 32'(FL_B));
        for (int i = 0; i < FL_B && i < addr_log.size(); i++) begin
            logic [AW-1:0] ea_addr;
            ea_addr = 10'd1020 + AW'(i);
            check($sformatf("t6_raddr%0d", i), 32'(addr_log[i]), 32'(ea_addr));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mu_ram_rd_stream.md
Name: mu_ram_rd_stream

Overview:
- Read-side sequencer for the simple dual-port frame RAM: on start, walks FRAME_LEN consecutive read addresses from a latched base address.
- Absorbs the RAM's 1-cycle registered read latency and presents pixels as a valid/ready stream to the downstream colour-map/video stage.
- Sustains full throughput: one pixel per cycle while m_ready is held high.

Parameters:
- DW, 8, pixel/data width (matches the RAM data width)
- AW, 10, RAM address width
- FRAME_LEN, 768, words per frame (32x24 thermal frame); legal range 1..2^AW

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to stream one frame
- base_addr  in  AW  first read address, sampled when start is accepted
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last beat is accepted
- ram_raddr  out  AW  RAM read address
- ram_re  out  1  RAM read enable
- ram_rd  in  DW  RAM read data, valid the cycle after ram_re
- m_valid  out  1  stream data valid
- m_ready  in  1  downstream ready
- m_data  out  DW  pixel
- m_last  out  1  high on the final beat of the frame

Behaviour:
- Reset values: busy=0, done=0, ram_re=0, ram_raddr=0, m_valid=0, m_data=0, m_last=0; skid buffer empty, counters zero.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: on start, latch base_addr into the address register, clear issue and beat counters, go to RUN, busy=1 from the next cycle.
  - start is ignored while busy.
- RUN: each cycle, ram_re=1 iff issued<FRAME_LEN and (fifo_count + inflight - pop) < 2.
  - inflight = ram_re of the previous cycle.
  - pop = m_valid & m_ready.
  - ram_raddr is the address register; it increments on each issue and wraps modulo 2^AW (base 1020, AW=10 -> 1020..1023, 0, 1...).
  - Move to DRAIN once issued==FRAME_LEN.
- Capture: in the cycle after ram_re, ram_rd is pushed into a 2-entry skid FIFO.
  - The credit rule guarantees the FIFO never overflows; pushing to a full FIFO is a design error (assertion).
- Output:
  - m_valid = FIFO not empty.
  - m_data is the FIFO head.
  - m_data/m_last hold stable while m_valid & !m_ready.
- m_last is high iff the head entry is beat index FRAME_LEN-1 (beat counter compare).
- DRAIN: no issues. When the last beat pops, go to IDLE; busy=0 and done=1 in the next cycle (done lasts exactly 1 cycle).
  - start in that same done cycle is accepted.
- Throughput: with m_ready=1 throughout, first m_valid is 2 cycles after start, and the last beat occurs at start+FRAME_LEN+1.
- Backpressure: any m_ready pattern loses and duplicates no data; order is preserved.
- FRAME_LEN=1: single beat with m_last=1.
- rst_n asserted mid-frame: immediately returns to reset values; in-flight RAM data is discarded.

Optional Feature:
- MU_RAM_RD_STREAM_XY_EN.
- Defined: adds parameter LINE_W (default 32) and outputs m_x [$clog2(LINE_W)] and m_y [$clog2(FRAME_LEN/LINE_W)] giving the head beat's column/row, plus m_eol high when m_x==LINE_W-1.
  - Coordinates advance with pops, x wraps to 0 and y increments; both reset to 0 at start.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package mu_pkg:
  - FSM state enum (ST_IDLE, ST_RUN, ST_DRAIN)
  - default thermal frame constants (FRAME_W=32, FRAME_H=24, FRAME_LEN=768)
- One natural sub-module: mu_skid_fifo2 (2-entry FIFO with count, push/pop, empty/full), reusable elsewhere.
- Bench pairs this block with the frame RAM model.

Test Plan:
- RAM preloaded mem[i]=i[7:0]; base=0, m_ready=1, start -> 768 beats 0x00..0xFF repeating, contiguous; m_last only on beat 767; done one cycle after it.
- base=1020, FRAME_LEN=8 -> ram_raddr 1020,1021,1022,1023,0,1,2,3; data mem[1020]...mem[3] in order.
- m_ready random 50% -> output sequence identical to the ready=1 run; no FIFO overflow assertion; m_data stable while stalled.
- m_ready=0 for 10 cycles after start -> ram_re issues exactly 2 reads and then stops; release yields beats 0,1,2... with no gaps or repeats.
- start while busy -> ignored (issue count unchanged); start in the done cycle -> second frame starts, busy re-asserts next cycle.
- rst_n low at beat 100 -> all outputs 0 immediately; new start streams from beat 0 correctly; with XY_EN, beat 33 -> m_x=1, m_y=1.
